// File: rtl/rc4_stream_cipher.sv
// ============================================================================
// rc4_stream_cipher
// ----------------------------------------------------------------------------
// Byte-serial RC4 engine. On start the key is captured, S is initialised to the
// identity permutation (two entries per cycle), and the key-scheduling pass
// runs at three cycles per index. The block then sits in WAIT accepting one
// byte at a time; each byte advances the PRGA by one step and is XORed with
// the resulting keystream byte. Encryption and decryption are the same.
//
// Compile option:
//   RC4_DROP_EN - after key scheduling, run and discard DROP_N PRGA steps
//                 (5 cycles each) before the first byte is accepted.
//
// Parameters:
//   KEY_BYTES  key length in bytes (1..32)
//   DROP_N     keystream bytes discarded after key setup (RC4_DROP_EN only)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   start      begin key setup with the current key (IDLE or WAIT only)
//   key        key; byte k = key[8k+7:8k]
//   key_ready  high while waiting for a byte (key setup complete)
//   in_valid / in_ready / in_data     input byte handshake
//   out_valid / out_ready / out_data  output byte handshake
//   busy       high in every state except IDLE and WAIT
// ============================================================================
module rc4_stream_cipher #(
    parameter int KEY_BYTES = 3,
    parameter int DROP_N    = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [KEY_BYTES*8-1:0] key,
    output logic                   key_ready,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_data,
    output logic                   busy
);

    localparam int KIW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    generate
        if (KEY_BYTES < 1 || KEY_BYTES > 32 || DROP_N < 0) begin : g_bad_param
            $error("rc4_stream_cipher: illegal KEY_BYTES or DROP_N");
        end
    endgenerate

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_KSA_RSI, S_KSA_RSJ, S_KSA_WR, S_WAIT,
        S_P_RSI, S_P_RSJ, S_P_WSI, S_P_WSJ, S_P_RK, S_OUT
`ifdef RC4_DROP_EN
        , S_DROP
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             i_q, i_d, j_q, j_d;
    logic [7:0]             si_q, si_d, sj_q, sj_d;
    logic [7:0]             in_q, in_d;
    logic [KEY_BYTES*8-1:0] key_q, key_d;
    logic [KIW-1:0]         kidx_q, kidx_d;
`ifdef RC4_DROP_EN
    logic [31:0]            drop_cnt_q, drop_cnt_d;
    logic [2:0]             phase_q, phase_d;
`endif

    // S-box RAM: two ports, each with a registered (read-first) read.
    logic [7:0] s_mem [256];
    logic [7:0] addr_a, addr_b, wdata_a, wdata_b;
    logic       we_a, we_b;
    logic [7:0] rd_a_q, rd_b_q;

    always_ff @(posedge clk) begin
        // In KSA_WR with i==j both ports write the same value, so order is moot.
        if (we_a) s_mem[addr_a] <= wdata_a;
        if (we_b) s_mem[addr_b] <= wdata_b;
        rd_a_q <= s_mem[addr_a];
        rd_b_q <= s_mem[addr_b];
    end

    logic [7:0] key_byte, ksa_j, prga_j, k_addr;
    assign key_byte = key_q[8*kidx_q +: 8];
    assign ksa_j    = j_q + rd_a_q + key_byte;  // rd_a_q holds S[i]
    assign prga_j   = j_q + rd_a_q;
    assign k_addr   = si_q + sj_q;              // equals S[i]+S[j] after the swap

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            i_q        <= 8'd0;
            j_q        <= 8'd0;
            si_q       <= 8'd0;
            sj_q       <= 8'd0;
            in_q       <= 8'd0;
            key_q      <= '0;
            kidx_q     <= '0;
`ifdef RC4_DROP_EN
            drop_cnt_q <= 32'd0;
            phase_q    <= 3'd0;
`endif
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            si_q       <= si_d;
            sj_q       <= sj_d;
            in_q       <= in_d;
            key_q      <= key_d;
            kidx_q     <= kidx_d;
`ifdef RC4_DROP_EN
            drop_cnt_q <= drop_cnt_d;
            phase_q    <= phase_d;
`endif
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        in_d    = in_q;
        key_d   = key_q;
        kidx_d  = kidx_q;
`ifdef RC4_DROP_EN
        drop_cnt_d = drop_cnt_q;
        phase_d    = phase_q;
`endif
        case (state_q)
            S_IDLE, S_WAIT: begin
                // start wins over a simultaneous byte offer in WAIT
                if (start) begin
                    state_d = S_INIT;
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                    key_d   = key;
                    kidx_d  = '0;
                end else if (state_q == S_WAIT && in_valid) begin
                    state_d = S_P_RSI;
                    in_d    = in_data;
                    i_d     = i_q + 8'd1;
                end
            end
            S_INIT: begin
                i_d = i_q + 8'd2;           // wraps to 0 after the last pair
                if (i_q == 8'd254) state_d = S_KSA_RSI;
            end
            S_KSA_RSI: state_d = S_KSA_RSJ;
            S_KSA_RSJ: begin
                si_d    = rd_a_q;
                j_d     = ksa_j;
                kidx_d  = (kidx_q == KIW'(KEY_BYTES - 1)) ? '0 : kidx_q + 1'b1;
                state_d = S_KSA_WR;
            end
            S_KSA_WR: begin
                i_d = i_q + 8'd1;
                if (i_q == 8'd255) begin
                    j_d = 8'd0;
`ifdef RC4_DROP_EN
                    drop_cnt_d = 32'd0;
                    phase_d    = 3'd0;
                    state_d    = (DROP_N > 0) ? S_DROP : S_WAIT;
`else
                    state_d = S_WAIT;
`endif
                end else begin
                    state_d = S_KSA_RSI;
                end
            end
            S_P_RSI: state_d = S_P_RSJ;
            S_P_RSJ: begin
                si_d    = rd_a_q;
                j_d     = prga_j;
                state_d = S_P_WSI;
            end
            S_P_WSI: begin
                sj_d    = rd_b_q;
                state_d = S_P_WSJ;
            end
            S_P_WSJ: state_d = S_P_RK;
            S_P_RK:  state_d = S_OUT;
            S_OUT:   if (out_ready) state_d = S_WAIT;
`ifdef RC4_DROP_EN
            S_DROP: begin
                // One PRGA step in five phases, mirroring P_RSI..P_RK.
                phase_d = (phase_q == 3'd4) ? 3'd0 : phase_q + 3'd1;
                case (phase_q)
                    3'd0: i_d = i_q + 8'd1;
                    3'd1: begin
                        si_d = rd_a_q;
                        j_d  = prga_j;
                    end
                    3'd2: sj_d = rd_b_q;
                    3'd4: begin
                        drop_cnt_d = drop_cnt_q + 32'd1;
                        if (drop_cnt_q == 32'(DROP_N - 1)) state_d = S_WAIT;
                    end
                    default: ;
                endcase
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- outputs and RAM control ----------------
    always_comb begin
        addr_a    = i_q;
        addr_b    = j_q;
        wdata_a   = 8'd0;
        wdata_b   = 8'd0;
        we_a      = 1'b0;
        we_b      = 1'b0;
        key_ready = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'd0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: busy = 1'b0;
            S_WAIT: begin
                busy      = 1'b0;
                key_ready = 1'b1;
                in_ready  = 1'b1;
            end
            S_INIT: begin
                we_a    = 1'b1;
                wdata_a = i_q;
                we_b    = 1'b1;
                addr_b  = {i_q[7:1], 1'b1};
                wdata_b = {i_q[7:1], 1'b1};
            end
            S_KSA_RSJ: addr_b = ksa_j;
            S_KSA_WR: begin
                we_a    = 1'b1;
                wdata_a = rd_b_q;
                we_b    = 1'b1;
                wdata_b = si_q;
            end
            S_P_RSJ: addr_b = prga_j;
            S_P_WSI: begin
                we_a    = 1'b1;
                wdata_a = rd_b_q;
            end
            S_P_WSJ: begin
                we_b    = 1'b1;
                wdata_b = si_q;
            end
            S_P_RK: addr_a = k_addr;
            S_OUT: begin
                // Address held so the keystream byte stays stable under backpressure.
                addr_a    = k_addr;
                out_valid = 1'b1;
                out_data  = in_q ^ rd_a_q;
            end
`ifdef RC4_DROP_EN
            S_DROP: begin
                case (phase_q)
                    3'd0: addr_a = i_q + 8'd1;
                    3'd1: addr_b = prga_j;
                    3'd2: begin
                        we_a    = 1'b1;
                        wdata_a = rd_b_q;
                    end
                    3'd3: begin
                        we_b    = 1'b1;
                        wdata_b = si_q;
                    end
                    default: ;
                endcase
            end
`endif
            default: ;
        endcase
    end

endmodule
